// File: rtl/unidade_load_store.sv
// Load/store unit in front of the data ram: word-granular read-modify-write for stores, extract/extend for loads.
// Optional LSU_ESTATISTICAS_EN adds per-class 32-bit response counters.
module unidade_load_store #(
  parameter int BITS     = 63,
  parameter int MEM_SIZE = 31
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req_valido,
  output logic          req_pronto,
  input  logic          req_escrita,
  input  logic [1:0]    req_tamanho,
  input  logic          req_sem_sinal,
  input  logic [BITS:0] req_endereco,
  input  logic [BITS:0] req_dado,
  output logic          resp_valido,
  input  logic          resp_pronto,
  output logic [BITS:0] resp_dado,
  output logic          resp_erro,
  output logic [BITS:0] mem_endereco,
  output logic          mem_permisao_escrita,
  output logic [BITS:0] mem_dado_escrita,
  input  logic [BITS:0] mem_dado_leitura
`ifdef LSU_ESTATISTICAS_EN
  ,
  output logic [31:0]   cont_loads,
  output logic [31:0]   cont_stores,
  output logic [31:0]   cont_erros
`endif
);

  // state    | meaning
  // OCIOSO   | idle, req_pronto=1, waiting for a request
  // LER      | ram word addressed, read data consumed at end of cycle
  // ESCREVER | write-enable pulse with merged (or full double) data
  // RESPOSTA | resp_valido held until resp_pronto
  typedef enum logic [1:0] {OCIOSO, LER, ESCREVER, RESPOSTA} estado_t;

  localparam logic [BITS:0] LIMITE = (BITS+1)'(MEM_SIZE);

  estado_t       estado_q, estado_d;
  logic          escrita_q, escrita_d;
  logic [1:0]    tamanho_q, tamanho_d;
  logic          sem_sinal_q, sem_sinal_d;
  logic [2:0]    off_q, off_d;
  logic [BITS:0] dado_q, dado_d;
  logic          req_pronto_q, req_pronto_d;
  logic          resp_valido_q, resp_valido_d;
  logic [BITS:0] resp_dado_q, resp_dado_d;
  logic          resp_erro_q, resp_erro_d;
  logic [BITS:0] mem_endereco_q, mem_endereco_d;
  logic          mem_we_q, mem_we_d;
  logic [BITS:0] mem_wdata_q, mem_wdata_d;

  logic [BITS:0] palavra;
  logic          desalinhado;
  logic          erro_captura;
  logic [5:0]    desloc;
  logic [BITS:0] mascara_tam;
  logic [BITS:0] mascara_pos;
  logic [BITS:0] dado_fundido;
  logic [BITS:0] extraido;
  logic [BITS:0] carga;

  always_comb begin
    palavra = req_endereco >> 3;
    desalinhado = 1'b0;
    case (req_tamanho)
      2'b01:   desalinhado = req_endereco[0];
      2'b10:   desalinhado = |req_endereco[1:0];
      2'b11:   desalinhado = |req_endereco[2:0];
      default: desalinhado = 1'b0;
    endcase
    erro_captura = desalinhado || (palavra > LIMITE);
  end

  // Merge and extraction both work on the live ram word; results are registered.
  always_comb begin
    desloc = {off_q, 3'b000};
    mascara_tam = '0;
    case (tamanho_q)
      2'b00:   mascara_tam[7:0]  = '1;
      2'b01:   mascara_tam[15:0] = '1;
      2'b10:   mascara_tam[31:0] = '1;
      default: mascara_tam       = '1;
    endcase
    mascara_pos  = mascara_tam << desloc;
    dado_fundido = (mem_dado_leitura & ~mascara_pos) | ((dado_q & mascara_tam) << desloc);
    extraido     = mem_dado_leitura >> desloc;
    case (tamanho_q)
      2'b00:   carga = sem_sinal_q ? {{(BITS-7){1'b0}}, extraido[7:0]}
                                   : {{(BITS-7){extraido[7]}}, extraido[7:0]};
      2'b01:   carga = sem_sinal_q ? {{(BITS-15){1'b0}}, extraido[15:0]}
                                   : {{(BITS-15){extraido[15]}}, extraido[15:0]};
      2'b10:   carga = sem_sinal_q ? {{(BITS-31){1'b0}}, extraido[31:0]}
                                   : {{(BITS-31){extraido[31]}}, extraido[31:0]};
      default: carga = extraido;
    endcase
  end

  always_comb begin
    estado_d       = estado_q;
    escrita_d      = escrita_q;
    tamanho_d      = tamanho_q;
    sem_sinal_d    = sem_sinal_q;
    off_d          = off_q;
    dado_d         = dado_q;
    req_pronto_d   = req_pronto_q;
    resp_valido_d  = resp_valido_q;
    resp_dado_d    = resp_dado_q;
    resp_erro_d    = resp_erro_q;
    mem_endereco_d = mem_endereco_q;
    mem_we_d       = 1'b0;
    mem_wdata_d    = '0;
    case (estado_q)
      OCIOSO: begin
        if (req_valido) begin
          escrita_d      = req_escrita;
          tamanho_d      = req_tamanho;
          sem_sinal_d    = req_sem_sinal;
          off_d          = req_endereco[2:0];
          dado_d         = req_dado;
          mem_endereco_d = palavra;
          req_pronto_d   = 1'b0;
          if (erro_captura) begin
            estado_d      = RESPOSTA;
            resp_valido_d = 1'b1;
            resp_erro_d   = 1'b1;
            resp_dado_d   = '0;
          end else if (req_escrita && (req_tamanho == 2'b11)) begin
            estado_d    = ESCREVER;
            mem_we_d    = 1'b1;
            mem_wdata_d = req_dado;
          end else begin
            estado_d = LER;
          end
        end
      end
      LER: begin
        if (escrita_q) begin
          estado_d    = ESCREVER;
          mem_we_d    = 1'b1;
          mem_wdata_d = dado_fundido;
        end else begin
          estado_d      = RESPOSTA;
          resp_valido_d = 1'b1;
          resp_dado_d   = carga;
        end
      end
      ESCREVER: begin
        estado_d      = RESPOSTA;
        resp_valido_d = 1'b1;
        resp_dado_d   = '0;
      end
      default: begin
        if (resp_pronto) begin
          estado_d       = OCIOSO;
          resp_valido_d  = 1'b0;
          resp_erro_d    = 1'b0;
          resp_dado_d    = '0;
          req_pronto_d   = 1'b1;
          mem_endereco_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q       <= OCIOSO;
      escrita_q      <= 1'b0;
      tamanho_q      <= 2'b00;
      sem_sinal_q    <= 1'b0;
      off_q          <= 3'b000;
      dado_q         <= '0;
      req_pronto_q   <= 1'b1;
      resp_valido_q  <= 1'b0;
      resp_dado_q    <= '0;
      resp_erro_q    <= 1'b0;
      mem_endereco_q <= '0;
      mem_we_q       <= 1'b0;
      mem_wdata_q    <= '0;
    end else begin
      estado_q       <= estado_d;
      escrita_q      <= escrita_d;
      tamanho_q      <= tamanho_d;
      sem_sinal_q    <= sem_sinal_d;
      off_q          <= off_d;
      dado_q         <= dado_d;
      req_pronto_q   <= req_pronto_d;
      resp_valido_q  <= resp_valido_d;
      resp_dado_q    <= resp_dado_d;
      resp_erro_q    <= resp_erro_d;
      mem_endereco_q <= mem_endereco_d;
      mem_we_q       <= mem_we_d;
      mem_wdata_q    <= mem_wdata_d;
    end
  end

  assign req_pronto           = req_pronto_q;
  assign resp_valido          = resp_valido_q;
  assign resp_dado            = resp_dado_q;
  assign resp_erro            = resp_erro_q;
  assign mem_endereco         = mem_endereco_q;
  assign mem_permisao_escrita = mem_we_q;
  assign mem_dado_escrita     = mem_wdata_q;

`ifdef LSU_ESTATISTICAS_EN
  logic [31:0] cont_loads_q, cont_loads_d;
  logic [31:0] cont_stores_q, cont_stores_d;
  logic [31:0] cont_erros_q, cont_erros_d;

  always_comb begin
    cont_loads_d  = cont_loads_q;
    cont_stores_d = cont_stores_q;
    cont_erros_d  = cont_erros_q;
    if ((estado_q == RESPOSTA) && resp_pronto) begin
      if (resp_erro_q)    cont_erros_d  = cont_erros_q + 32'd1;
      else if (escrita_q) cont_stores_d = cont_stores_q + 32'd1;
      else                cont_loads_d  = cont_loads_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cont_loads_q  <= '0;
      cont_stores_q <= '0;
      cont_erros_q  <= '0;
    end else begin
      cont_loads_q  <= cont_loads_d;
      cont_stores_q <= cont_stores_d;
      cont_erros_q  <= cont_erros_d;
    end
  end

  assign cont_loads  = cont_loads_q;
  assign cont_stores = cont_stores_q;
  assign cont_erros  = cont_erros_q;
`endif

endmodule

// File: tb/tb_unidade_load_store.sv
// Directed bench for unidade_load_store with a behavioural 32-word ram preloaded ram[i]=i.
module tb_unidade_load_store;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valido;
  logic        req_pronto;
  logic        req_escrita;
  logic [1:0]  req_tamanho;
  logic        req_sem_sinal;
  logic [63:0] req_endereco;
  logic [63:0] req_dado;
  logic        resp_valido;
  logic        resp_pronto;
  logic [63:0] resp_dado;
  logic        resp_erro;
  logic [63:0] mem_endereco;
  logic        mem_permisao_escrita;
  logic [63:0] mem_dado_escrita;
  logic [63:0] mem_dado_leitura;
`ifdef LSU_ESTATISTICAS_EN
  logic [31:0] cont_loads, cont_stores, cont_erros;
`endif

  unidade_load_store #(.BITS(63), .MEM_SIZE(31)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valido(req_valido), .req_pronto(req_pronto), .req_escrita(req_escrita),
    .req_tamanho(req_tamanho), .req_sem_sinal(req_sem_sinal),
    .req_endereco(req_endereco), .req_dado(req_dado),
    .resp_valido(resp_valido), .resp_pronto(resp_pronto),
    .resp_dado(resp_dado), .resp_erro(resp_erro),
    .mem_endereco(mem_endereco), .mem_permisao_escrita(mem_permisao_escrita),
    .mem_dado_escrita(mem_dado_escrita), .mem_dado_leitura(mem_dado_leitura)
`ifdef LSU_ESTATISTICAS_EN
    , .cont_loads(cont_loads), .cont_stores(cont_stores), .cont_erros(cont_erros)
`endif
  );

  always #5 clock = ~clock;

  logic [63:0] ram [0:31];
  logic        carregar;
  int          wr_count;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;

  assign mem_dado_leitura = (mem_endereco < 64'd32) ? ram[mem_endereco[4:0]] : 64'd0;

  always @(posedge clock) begin
    if (carregar) begin
      for (int i = 0; i < 32; i++) ram[i] <= 64'(i);
      wr_count <= 0;
    end else if (mem_permisao_escrita) begin
      ram[mem_endereco[4:0]] <= mem_dado_escrita;
      wr_count <= wr_count + 1;
      wr_addr  <= mem_endereco[4:0];
      wr_data  <= mem_dado_escrita;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string nome, input int idx, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", nome, idx, got, exp);
    end
  endfunction

  typedef struct {
    logic        esc;
    logic [1:0]  tam;
    logic        ss;
    logic [63:0] addr;
    logic [63:0] dado;
    logic [63:0] exp_dado;
    logic        exp_erro;
    int          exp_lat;
    int          exp_wr;
    logic [4:0]  exp_waddr;
    logic [63:0] exp_wdata;
  } vec_t;

  vec_t vecs [15];

  task automatic run_req(input vec_t v, input int idx);
    int lat;
    int w0;
    @(negedge clock);
    chk("req_pronto_idle", idx, 64'(req_pronto), 64'd1);
    req_valido    = 1'b1;
    req_escrita   = v.esc;
    req_tamanho   = v.tam;
    req_sem_sinal = v.ss;
    req_endereco  = v.addr;
    req_dado      = v.dado;
    w0 = wr_count;
    @(posedge clock); #1;
    req_valido = 1'b0;
    lat = 1;
    while (!resp_valido && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("latency", idx, 64'(lat), 64'(v.exp_lat));
    chk("resp_dado", idx, resp_dado, v.exp_dado);
    chk("resp_erro", idx, 64'(resp_erro), 64'(v.exp_erro));
    @(posedge clock); #1;
    chk("resp_valido_drop", idx, 64'(resp_valido), 64'd0);
    chk("write_pulses", idx, 64'(wr_count - w0), 64'(v.exp_wr));
    if (v.exp_wr == 1) begin
      chk("write_addr", idx, 64'(wr_addr), 64'(v.exp_waddr));
      chk("write_data", idx, wr_data, v.exp_wdata);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   w0;
    //          esc  tam   ss   addr      dado                    exp_dado                erro lat wr waddr wdata
    vecs[0]  = '{1'b0, 2'd3, 1'b0, 64'h28,  64'h0,                  64'h5,                  1'b0, 2, 0, 5'd0, 64'h0};
    vecs[1]  = '{1'b1, 2'd0, 1'b0, 64'h29,  64'hAB,                 64'h0,                  1'b0, 3, 1, 5'd5, 64'hAB05};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 64'h29,  64'h0,                  64'hFFFFFFFFFFFFFFAB,   1'b0, 2, 0, 5'd0, 64'h0};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 64'h29,  64'h0,                  64'hAB,                 1'b0, 2, 0, 5'd0, 64'h0};
    vecs[4]  = '{1'b1, 2'd1, 1'b0, 64'h06,  64'h1234,               64'h0,                  1'b0, 3, 1, 5'd0, 64'h1234000000000000};
    vecs[5]  = '{1'b0, 2'd2, 1'b1, 64'h04,  64'h0,                  64'h12340000,           1'b0, 2, 0, 5'd0, 64'h0};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 64'h03,  64'h0,                  64'h0,                  1'b1, 1, 0, 5'd0, 64'h0};
    vecs[7]  = '{1'b0, 2'd3, 1'b0, 64'h100, 64'h0,                  64'h0,                  1'b1, 1, 0, 5'd0, 64'h0};
    vecs[8]  = '{1'b1, 2'd3, 1'b0, 64'h18,  64'hDEADBEEF01234567,   64'h0,                  1'b0, 2, 1, 5'd3, 64'hDEADBEEF01234567};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 64'h1C,  64'h0,                  64'hFFFFFFFFDEADBEEF,   1'b0, 2, 0, 5'd0, 64'h0};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 64'h18,  64'h0,                  64'h4567,               1'b0, 2, 0, 5'd0, 64'h0};
    vecs[11] = '{1'b1, 2'd2, 1'b0, 64'h0A,  64'h55,                 64'h0,                  1'b1, 1, 0, 5'd0, 64'h0};
    vecs[12] = '{1'b1, 2'd2, 1'b0, 64'h1C,  64'hFFFFFFFF80000001,   64'h0,                  1'b0, 3, 1, 5'd3, 64'h8000000101234567};
    vecs[13] = '{1'b0, 2'd2, 1'b0, 64'h1C,  64'h0,                  64'hFFFFFFFF80000001,   1'b0, 2, 0, 5'd0, 64'h0};
    vecs[14] = '{1'b0, 2'd3, 1'b0, 64'hF8,  64'h0,                  64'h1F,                 1'b0, 2, 0, 5'd0, 64'h0};

    reset_n = 1'b0; carregar = 1'b1;
    req_valido = 1'b0; req_escrita = 1'b0; req_tamanho = 2'd0; req_sem_sinal = 1'b0;
    req_endereco = '0; req_dado = '0; resp_pronto = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req_pronto", 0, 64'(req_pronto), 64'd1);
    chk("rst_resp_valido", 0, 64'(resp_valido), 64'd0);
    chk("rst_mem_we", 0, 64'(mem_permisao_escrita), 64'd0);
    chk("rst_resp_dado", 0, resp_dado, 64'd0);
    chk("rst_mem_endereco", 0, mem_endereco, 64'd0);
    @(negedge clock);
    reset_n = 1'b1; carregar = 1'b0;

    for (int i = 0; i < 15; i++) run_req(vecs[i], i);

    // Response stall: load double at 0x10 with resp_pronto low for 5 cycles.
    resp_pronto = 1'b0;
    v = '{1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 64'h2, 1'b0, 2, 0, 5'd0, 64'h0};
    @(negedge clock);
    req_valido = 1'b1; req_escrita = v.esc; req_tamanho = v.tam;
    req_sem_sinal = v.ss; req_endereco = v.addr; req_dado = v.dado;
    @(posedge clock); #1;
    req_valido = 1'b0;
    @(posedge clock); #1;
    for (int c = 0; c < 5; c++) begin
      chk("stall_valido", c, 64'(resp_valido), 64'd1);
      chk("stall_dado", c, resp_dado, 64'h2);
      chk("stall_req_pronto", c, 64'(req_pronto), 64'd0);
      @(posedge clock); #1;
    end
    @(negedge clock);
    resp_pronto = 1'b1;
    @(posedge clock); #1;
    chk("stall_release_valido", 0, 64'(resp_valido), 64'd0);
    chk("stall_release_pronto", 0, 64'(req_pronto), 64'd1);

    // Reset during the read phase of a byte store to 0x10.
    w0 = wr_count;
    @(negedge clock);
    req_valido = 1'b1; req_escrita = 1'b1; req_tamanho = 2'd0;
    req_sem_sinal = 1'b0; req_endereco = 64'h10; req_dado = 64'h77;
    @(posedge clock); #1;
    req_valido = 1'b0;
    chk("abort_in_ler_pronto", 0, 64'(req_pronto), 64'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_mem_we", 0, 64'(mem_permisao_escrita), 64'd0);
    chk("abort_req_pronto", 0, 64'(req_pronto), 64'd1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("abort_write_pulses", 0, 64'(wr_count - w0), 64'd0);
    chk("abort_ram2", 0, ram[2], 64'h2);
    chk("abort_req_pronto_after", 0, 64'(req_pronto), 64'd1);
`ifdef LSU_ESTATISTICAS_EN
    chk("abort_cont_loads", 0, 64'(cont_loads), 64'd0);
    chk("abort_cont_stores", 0, 64'(cont_stores), 64'd0);
    chk("abort_cont_erros", 0, 64'(cont_erros), 64'd0);
`endif
    v = '{1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 64'h2, 1'b0, 2, 0, 5'd0, 64'h0};
    run_req(v, 100);
`ifdef LSU_ESTATISTICAS_EN
    chk("post_cont_loads", 0, 64'(cont_loads), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
